display_scan_timing: RTL
========================

// Module: display_scan_timing
// PURPOSE
// - Timing source for the 4-digit multiplexed display. Generates the three select
//   strobes for the downstream anode-select mux: clock2segs (0 = scoreboard
//   T1/T2, 1 = chronometer), clock60hz (digit-pair select) and clock120hz (digit
//   within pair).
// - All outputs are registered and change only on the single system clock, so the
//   downstream mux never sees a mid-frame mode switch.
// PARAMETERS
// - CLK_HZ       50_000_000  system clock frequency in Hz
// - DIGIT_HZ     480         digit-slot rate in Hz; each digit refreshes at DIGIT_HZ/4
// - ALT_SECONDS  2           seconds per display mode (scoreboard <-> chronometer)
// - BLANK_CYCLES 64          blanking length per slot; used only with SCAN_BLANK_EN
// PORTS
// - clock       in   1  system clock, rising edge
// - reset_n     in   1  asynchronous active-low reset
// - hold_mode   in   1  1 = freeze current mode and clear the alternation timer
// - clock2segs  out  1  mode select: 0 scoreboard, 1 chronometer
// - clock60hz   out  1  digit counter bit 1
// - clock120hz  out  1  digit counter bit 0
// - digit_tick  out  1  one-cycle pulse on the first cycle of every digit slot
// - blank       out  1  1 = blank anodes (always 0 without SCAN_BLANK_EN)
// BEHAVIOUR
// - Reset: all counters 0, clock2segs=0, clock60hz=0, clock120hz=0, digit_tick=0,
//   blank=0, pending=0. Reset asserted mid-frame aborts the frame immediately.
// - DIV = CLK_HZ/DIGIT_HZ (integer, truncated). DIV < 2 is an elaboration error.
//   ALT = CLK_HZ*ALT_SECONDS, computed at 64 bits. Counter widths use $clog2(DIV)
//   and $clog2(ALT).
// - Slot counter: counts 0..DIV-1 and wraps to 0. On each wrap:
//   - the 2-bit digit counter {clock60hz,clock120hz} increments 0->1->2->3->0;
//   - digit_tick pulses in the same cycle the new digit value appears.
// - The first digit_tick after reset is DIV cycles after reset release.
// - Alternation counter: counts 0..ALT-1 and wraps. On wrap it sets pending=1.
// - Mode change: clock2segs toggles only at a frame boundary, i.e. on the slot wrap
//   where the digit counter goes 3->0, and only if pending=1 or pending is being set
//   in that same cycle. pending clears when the toggle happens.
// - Only one toggle per frame; repeated wraps while pending=1 do not queue a second
//   toggle.
// - hold_mode=1: the alternation counter and pending are forced to 0 every cycle.
//   clock2segs holds its value. The digit scan keeps running.
// - hold_mode falling: the alternation counter restarts from 0, so a full ALT cycles
//   elapse before the next pending.
// - Chronometer mode: the downstream mux uses only clock60hz. Its outputs repeat each
//   frame, and this block does not change the scan in that mode.
// CONFIGURATION
// - `SCAN_BLANK_EN defined: blank=1 for slot-counter values 0..BLANK_CYCLES-1 of every
//   slot, so it rises with digit_tick and suppresses ghosting.
//   - BLANK_CYCLES >= DIV is clamped to DIV-1.
//   - BLANK_CYCLES = 0 means blank is never asserted.
//   - blank is 0 during reset.
// - `SCAN_BLANK_EN undefined: blank is tied to 0 and no blank logic is generated.
// TESTING (CLK_HZ=16, DIGIT_HZ=4 -> DIV=4; ALT_SECONDS=2 -> ALT=32; BLANK_CYCLES=1)
// - Release reset, run 20 cycles -> digit_tick at cycles 4,8,12,16,20.
//   {clock60hz,clock120hz} reads 1,2,3,0,1. clock2segs=0.
// - Run free -> clock2segs toggles exactly at cycle 32, then at 64 and 96, each time
//   together with a digit 3->0 wrap.
// - Hold hold_mode=1 during cycles 20..40, then release -> no toggle at 32.
//   The next toggle is at cycle 80 (timer restarts at 41; pending at 72; wrap at 80).
// - Assert reset_n=0 at cycle 30 for 3 cycles -> all outputs 0 immediately, with no
//   clock edge needed. After release the sequence restarts as in the first test.
// - Run with `SCAN_BLANK_EN -> blank=1 exactly on digit_tick cycles and 0 otherwise.
//   Without the macro, blank stays 0 for the whole run.
// - Parameter sweep DIGIT_HZ=16 (DIV=1) -> elaboration fails with an error message.

Source files
------------

// File: rtl/display_scan_timing.sv
// display_scan_timing: slot, digit and mode-alternation strobes for the 4-digit display mux.
// Optional anode blanking is built only when SCAN_BLANK_EN is defined.
module display_scan_timing #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DIGIT_HZ     = 480,
  parameter int unsigned ALT_SECONDS  = 2,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic hold_mode,
  output logic clock2segs,
  output logic clock60hz,
  output logic clock120hz,
  output logic digit_tick,
  output logic blank
);

  localparam int unsigned     DIV       = CLK_HZ / DIGIT_HZ;
  localparam longint unsigned ALT       = 64'(CLK_HZ) * 64'(ALT_SECONDS);
  localparam int              DIV_W     = (DIV > 32'd1) ? $clog2(DIV) : 1;
  localparam int              ALT_W     = (ALT > 64'd1) ? $clog2(ALT) : 1;
  localparam logic [DIV_W-1:0] SLOT_LAST = DIV_W'(DIV - 32'd1);
  localparam logic [ALT_W-1:0] ALT_LAST  = ALT_W'(ALT - 64'd1);
  // Blanking never covers a whole slot, otherwise the digit would never light.
  localparam int unsigned     BLANK_EFF = (BLANK_CYCLES >= DIV) ? (DIV - 32'd1) : BLANK_CYCLES;

  if (DIV < 32'd2) begin : g_bad_div
    $error("display_scan_timing: CLK_HZ/DIGIT_HZ must be at least 2");
  end
  if ((DIV >= 32'd2) && (BLANK_EFF >= DIV)) begin : g_bad_blank
    $error("display_scan_timing: blanking length must be shorter than the slot");
  end

  logic [DIV_W-1:0] slot_r;
  logic [DIV_W-1:0] slot_next_s;
  logic [1:0]       digit_r;
  logic [1:0]       digit_next_s;
  logic [ALT_W-1:0] alt_r;
  logic [ALT_W-1:0] alt_next_s;
  logic             pending_r;
  logic             pending_next_s;
  logic             mode_r;
  logic             mode_next_s;
  logic             tick_r;
  logic             slot_wrap_s;
  logic             frame_wrap_s;
  logic             alt_wrap_s;
  logic             toggle_s;

  // Next-state for slot/digit scan, alternation timer, pending flag and mode.
  always_comb begin
    slot_next_s    = slot_r + DIV_W'(1);
    digit_next_s   = digit_r;
    alt_next_s     = alt_r + ALT_W'(1);
    pending_next_s = pending_r;
    mode_next_s    = mode_r;
    frame_wrap_s   = 1'b0;
    toggle_s       = 1'b0;
    slot_wrap_s    = (slot_r == SLOT_LAST);
    alt_wrap_s     = (alt_r == ALT_LAST);

    if (slot_wrap_s) begin
      slot_next_s  = {DIV_W{1'b0}};
      digit_next_s = digit_r + 2'd1;
      frame_wrap_s = (digit_r == 2'd3);
    end else begin
      slot_next_s  = slot_r + DIV_W'(1);
      digit_next_s = digit_r;
    end

    if (hold_mode) begin
      // Timer restarts from zero once hold is released; mode stays frozen.
      alt_next_s     = {ALT_W{1'b0}};
      pending_next_s = 1'b0;
      mode_next_s    = mode_r;
    end else begin
      if (alt_wrap_s) begin
        alt_next_s = {ALT_W{1'b0}};
      end else begin
        alt_next_s = alt_r + ALT_W'(1);
      end
      // A wrap landing exactly on the frame boundary toggles without waiting a frame.
      toggle_s = frame_wrap_s && (pending_r || alt_wrap_s);
      if (toggle_s) begin
        mode_next_s    = ~mode_r;
        pending_next_s = 1'b0;
      end else if (alt_wrap_s) begin
        mode_next_s    = mode_r;
        pending_next_s = 1'b1;
      end else begin
        mode_next_s    = mode_r;
        pending_next_s = pending_r;
      end
    end
  end

  // Counter and output registers; reset aborts any frame in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_r    <= {DIV_W{1'b0}};
      digit_r   <= 2'd0;
      alt_r     <= {ALT_W{1'b0}};
      pending_r <= 1'b0;
      mode_r    <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      slot_r    <= slot_next_s;
      digit_r   <= digit_next_s;
      alt_r     <= alt_next_s;
      pending_r <= pending_next_s;
      mode_r    <= mode_next_s;
      tick_r    <= slot_wrap_s;
    end
  end

  assign clock2segs = mode_r;
  assign clock60hz  = digit_r[1];
  assign clock120hz = digit_r[0];
  assign digit_tick = tick_r;

`ifdef SCAN_BLANK_EN
  logic blank_r;
  logic blank_next_s;

  // Blank covers the first BLANK_EFF cycles of each slot, rising with digit_tick.
  always_comb begin
    blank_next_s = (32'(slot_next_s) < BLANK_EFF);
  end

  // Registered blank so it aligns with the slot value it describes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blank_r <= 1'b0;
    end else begin
      blank_r <= blank_next_s;
    end
  end

  assign blank = blank_r;
`else
  assign blank = 1'b0;
`endif

endmodule
